// File: rtl/pair_filter_queue.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | pair_filter_queue: queues ring references, sweeps the neighbour snapshot    |
// | per reference and emits pairs whose squared distance lies inside cutoff.    |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module pair_filter_queue #(
   parameter int          NSIZE   = 14,
   parameter int          RDEPTH  = 16,
   parameter logic [67:0] CUTOFF2 = 68'h1_0000_0000_0000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [1:0]           dispatch,
   input  logic [114*NSIZE-1:0] neighbors,
   input  logic [113:0]         reference,
   input  logic                 done_batch_in,
   input  logic                 pair_ready,
   output logic                 pair_valid,
   output logic [113:0]         pair_ref,
   output logic [113:0]         pair_nbr,
   output logic [67:0]          pair_r2,
   output logic                 busy,
   output logic                 batch_done,
   output logic                 overflow,
   output logic [15:0]          drop_count
);
   localparam int c_AW = (RDEPTH > 1) ? $clog2(RDEPTH) : 1;
   localparam int c_CW = c_AW + 1;
   localparam int c_JW = (NSIZE > 1) ? $clog2(NSIZE) : 1;
   localparam logic [113:0]    c_NULL_WORD = {17'd0, 1'b1, 96'd0};
   localparam logic [c_CW-1:0] c_DEPTH     = c_CW'(RDEPTH);
   localparam logic [c_JW-1:0] c_LAST      = c_JW'(NSIZE - 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_SWEEP = 2'd1, S_DRAIN = 2'd2} state_t;

   state_t             state_q, state_d;
   logic [1:0]         dispatch_q;
   logic [c_JW-1:0]    j_q, j_d;
   logic [c_AW-1:0]    rd_q, rd_d, wr_q, wr_d;
   logic [c_CW-1:0]    cnt_q, cnt_d;
   logic               snap_valid_q, snap_valid_d, done_seen_q, done_seen_d;
   logic               batch_done_q, batch_done_d, overflow_q, overflow_d;
   logic [15:0]        drop_q, drop_d;
   logic [113:0]       fifo_q [RDEPTH];
   logic [113:0]       snap_q [NSIZE];
   logic               s1_v_q, s2_v_q, out_v_q;
   logic [113:0]       s1_ref_q, s1_nbr_q, s2_ref_q, s2_nbr_q, out_ref_q, out_nbr_q;
   logic signed [32:0] dx_q, dy_q, dz_q;
   logic [67:0]        s2_r2_q, out_r2_q;

   logic               w_flush, w_snap_load, w_pipe_busy, w_discard, w_clear, w_stall;
   logic               w_start, w_issue, w_last, w_pop, w_push_req, w_full, w_push, w_drop, w_pass;
   logic [113:0]       w_head, w_slot;
   logic signed [65:0] w_dxe, w_dye, w_dze;
   logic [65:0]        w_sqx, w_sqy, w_sqz;
   logic [67:0]        w_r2;

   function automatic logic signed [32:0] diff33(input logic [31:0] a, input logic [31:0] b);
      return $signed({a[31], a}) - $signed({b[31], b});
   endfunction

   assign w_flush     = (dispatch == 2'b11);
   assign w_snap_load = (dispatch_q == 2'b01) && !w_flush;
   assign w_pipe_busy = s1_v_q || s2_v_q || out_v_q;
   assign w_discard   = w_snap_load && ((cnt_q != '0) || w_pipe_busy);
   assign w_clear     = w_flush || w_discard;
   assign w_stall     = out_v_q && !pair_ready;
   assign w_head      = fifo_q[rd_q];
   assign w_slot      = snap_q[j_q];
   // IDLE issues slot 0 in the same cycle it sees work so the first pair lands three edges after intake.
   assign w_start     = (state_q == S_IDLE) && (cnt_q != '0) && snap_valid_q;
   assign w_issue     = ((state_q == S_SWEEP) || w_start) && !w_stall;
   assign w_last      = (j_q == c_LAST);
   assign w_pop       = w_issue && w_last;
   assign w_push_req  = !reference[96] && !w_flush;
   assign w_full      = (cnt_q == c_DEPTH) && !w_pop && !w_discard;
   assign w_push      = w_push_req && !w_full;
   assign w_drop      = w_push_req && w_full;

   assign w_dxe = 66'(dx_q);
   assign w_dye = 66'(dy_q);
   assign w_dze = 66'(dz_q);
   assign w_sqx = w_dxe * w_dxe;
   assign w_sqy = w_dye * w_dye;
   assign w_sqz = w_dze * w_dze;
   assign w_r2  = {2'b00, w_sqx} + {2'b00, w_sqy} + {2'b00, w_sqz};
   assign w_pass = s2_v_q && (s2_r2_q < CUTOFF2) && (s2_r2_q != '0);

   always_comb begin
      state_d = state_q;
      j_d     = j_q;
      rd_d    = rd_q + c_AW'(w_pop);
      wr_d    = wr_q + c_AW'(w_push);
      cnt_d   = cnt_q + c_CW'(w_push) - c_CW'(w_pop);
      if (w_issue) begin
         if (w_last) begin
            j_d     = '0;
            state_d = ((cnt_q > c_CW'(1)) || w_push) ? S_SWEEP : S_DRAIN;
         end else begin
            j_d     = j_q + 1'b1;
            state_d = S_SWEEP;
         end
      end else if ((state_q == S_DRAIN) && !w_pipe_busy) begin
         state_d = S_IDLE;
      end
      if (w_clear) begin
         state_d = S_IDLE;
         j_d     = '0;
         rd_d    = wr_q;
         cnt_d   = c_CW'(w_push);
      end
      snap_valid_d = w_flush ? 1'b0 : (w_snap_load ? 1'b1 : snap_valid_q);
      done_seen_d  = ((w_flush || w_snap_load) ? 1'b0 : done_seen_q) | (done_batch_in && !w_flush);
      batch_done_d = batch_done_q;
      if (w_flush || w_snap_load) begin
         batch_done_d = 1'b0;
      end else if (done_seen_q && (cnt_q == '0) && !w_pipe_busy) begin
         batch_done_d = 1'b1;
      end
      overflow_d = overflow_q | w_discard | w_drop;
      drop_d     = (w_drop && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         fifo_q[wr_q] <= reference;
      end
      if (w_snap_load) begin
         for (int k = 0; k < NSIZE; k++) begin
            snap_q[k] <= neighbors[k*114 +: 114];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         dispatch_q   <= 2'b00;
         j_q          <= '0;
         rd_q         <= '0;
         wr_q         <= '0;
         cnt_q        <= '0;
         snap_valid_q <= 1'b0;
         done_seen_q  <= 1'b0;
         batch_done_q <= 1'b0;
         overflow_q   <= 1'b0;
         drop_q       <= 16'd0;
         s1_v_q       <= 1'b0;
         s2_v_q       <= 1'b0;
         out_v_q      <= 1'b0;
         s1_ref_q     <= '0;
         s1_nbr_q     <= '0;
         s2_ref_q     <= '0;
         s2_nbr_q     <= '0;
         dx_q         <= '0;
         dy_q         <= '0;
         dz_q         <= '0;
         s2_r2_q      <= '0;
         out_ref_q    <= c_NULL_WORD;
         out_nbr_q    <= c_NULL_WORD;
         out_r2_q     <= '0;
      end else begin
         state_q      <= state_d;
         dispatch_q   <= dispatch;
         j_q          <= j_d;
         rd_q         <= rd_d;
         wr_q         <= wr_d;
         cnt_q        <= cnt_d;
         snap_valid_q <= snap_valid_d;
         done_seen_q  <= done_seen_d;
         batch_done_q <= batch_done_d;
         overflow_q   <= overflow_d;
         drop_q       <= drop_d;
         if (w_clear) begin
            s1_v_q    <= 1'b0;
            s2_v_q    <= 1'b0;
            out_v_q   <= 1'b0;
            out_ref_q <= c_NULL_WORD;
            out_nbr_q <= c_NULL_WORD;
            out_r2_q  <= '0;
         end else if (!w_stall) begin
            s1_v_q   <= w_issue && !w_slot[96];
            s1_ref_q <= w_head;
            s1_nbr_q <= w_slot;
            dx_q     <= diff33(w_head[31:0],  w_slot[31:0]);
            dy_q     <= diff33(w_head[63:32], w_slot[63:32]);
            dz_q     <= diff33(w_head[95:64], w_slot[95:64]);
            s2_v_q   <= s1_v_q;
            s2_ref_q <= s1_ref_q;
            s2_nbr_q <= s1_nbr_q;
            s2_r2_q  <= w_r2;
            out_v_q  <= w_pass;
            if (w_pass) begin
               out_ref_q <= s2_ref_q;
               out_nbr_q <= s2_nbr_q;
               out_r2_q  <= s2_r2_q;
            end
         end
      end
   end

   assign pair_valid = out_v_q;
   assign pair_ref   = out_ref_q;
   assign pair_nbr   = out_nbr_q;
   assign pair_r2    = out_r2_q;
   assign busy       = (cnt_q != '0) || w_pipe_busy;
   assign batch_done = batch_done_q;
   assign overflow   = overflow_q;
   assign drop_count = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_pair_filter_queue.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_pair_filter_queue: directed self-checking bench for pair_filter_queue.   |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_pair_filter_queue;
   localparam int NSIZE  = 14;
   localparam int RDEPTH = 16;
   localparam logic [113:0] NULL_W = {17'd0, 1'b1, 96'd0};

   logic                 clk = 1'b0;
   logic                 reset;
   logic [1:0]           dispatch;
   logic [114*NSIZE-1:0] neighbors;
   logic [113:0]         reference;
   logic                 done_batch_in;
   logic                 pair_ready;
   logic                 pair_valid;
   logic [113:0]         pair_ref;
   logic [113:0]         pair_nbr;
   logic [67:0]          pair_r2;
   logic                 busy;
   logic                 batch_done;
   logic                 overflow;
   logic [15:0]          drop_count;

   int n_checks = 0;
   int n_errors = 0;

   pair_filter_queue #(
      .NSIZE   (NSIZE),
      .RDEPTH  (RDEPTH),
      .CUTOFF2 (68'h1_0000_0000_0000)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .dispatch      (dispatch),
      .neighbors     (neighbors),
      .reference     (reference),
      .done_batch_in (done_batch_in),
      .pair_ready    (pair_ready),
      .pair_valid    (pair_valid),
      .pair_ref      (pair_ref),
      .pair_nbr      (pair_nbr),
      .pair_r2       (pair_r2),
      .busy          (busy),
      .batch_done    (batch_done),
      .overflow      (overflow),
      .drop_count    (drop_count)
   );

   always #5 clk = ~clk;

   function automatic logic [113:0] mkw(input int x, input int y, input int z);
      return {9'd0, 8'd0, 1'b0, z[31:0], y[31:0], x[31:0]};
   endfunction

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_slot(input int k, input logic [113:0] w);
      neighbors[k*114 +: 114] = w;
   endtask

   task automatic load_snap();
      dispatch = 2'b01;
      tick();
      dispatch = 2'b00;
      tick();
      tick();
   endtask

   initial begin
      int got;
      int extra;
      logic [67:0]  last_r2;
      logic [113:0] last_nbr;

      reset         = 1'b0;
      dispatch      = 2'b00;
      reference     = NULL_W;
      done_batch_in = 1'b0;
      pair_ready    = 1'b1;
      neighbors     = {NSIZE{NULL_W}};
      repeat (3) tick();
      check("rst_valid", 128'(pair_valid), 128'(0));
      check("rst_ref",   128'(pair_ref),   128'(NULL_W));
      check("rst_nbr",   128'(pair_nbr),   128'(NULL_W));
      check("rst_r2",    128'(pair_r2),    128'(0));
      check("rst_busy",  128'(busy),       128'(0));
      check("rst_bdone", 128'(batch_done), 128'(0));
      check("rst_ovf",   128'(overflow),   128'(0));
      check("rst_drop",  128'(drop_count), 128'(0));
      reset = 1'b1;
      tick();

      // Single passing neighbour (3,4,0) against origin: r2 = 25 three edges after intake
      set_slot(0, mkw(3, 4, 0));
      load_snap();
      reference = mkw(0, 0, 0);
      tick();
      reference = NULL_W;
      check("lat_t0", 128'(pair_valid), 128'(0));
      check("lat_busy", 128'(busy), 128'(1));
      tick();
      check("lat_t1", 128'(pair_valid), 128'(0));
      tick();
      check("lat_t2", 128'(pair_valid), 128'(0));
      tick();
      check("lat_t3", 128'(pair_valid), 128'(1));
      check("t1_r2",  128'(pair_r2),    128'(25));
      check("t1_nbr", 128'(pair_nbr),   128'(mkw(3, 4, 0)));
      check("t1_ref", 128'(pair_ref),   128'(mkw(0, 0, 0)));
      extra = 0;
      repeat (20) begin
         tick();
         if (pair_valid) extra++;
      end
      check("t1_extra", 128'(extra), 128'(0));

      // r2 == cutoff is rejected, (2^24-1)^2 just below it passes
      neighbors = {NSIZE{NULL_W}};
      set_slot(0, mkw(32'sd16777216, 0, 0));
      set_slot(1, mkw(-32'sd16777215, 0, 0));
      load_snap();
      reference = mkw(0, 0, 0);
      tick();
      reference = NULL_W;
      got = 0;
      last_r2 = '0;
      last_nbr = '0;
      repeat (30) begin
         tick();
         if (pair_valid) begin
            got++;
            last_r2 = pair_r2;
            last_nbr = pair_nbr;
         end
      end
      check("cut_count", 128'(got), 128'(1));
      check("cut_r2",    128'(last_r2), 128'(68'hFFFFFE000001));
      check("cut_nbr",   128'(last_nbr), 128'(mkw(-32'sd16777215, 0, 0)));
      check("cut_ovf",   128'(overflow), 128'(0));

      // FIFO overflow while output is stalled, then ordered drain
      neighbors = {NSIZE{NULL_W}};
      set_slot(0, mkw(0, 0, 0));
      load_snap();
      pair_ready = 1'b0;
      for (int i = 1; i <= 17; i++) begin
         reference = mkw(i, 0, 0);
         tick();
      end
      reference = NULL_W;
      check("ovf_flag",  128'(overflow),   128'(1));
      check("ovf_drop",  128'(drop_count), 128'(1));
      check("ovf_busy",  128'(busy),       128'(1));
      check("ovf_stall", 128'(pair_r2),    128'(1));
      pair_ready = 1'b1;
      got = 0;
      for (int cyc = 0; cyc < 400 && got < 16; cyc++) begin
         if (pair_valid) begin
            check("ord_r2",  128'(pair_r2),       128'((got + 1) * (got + 1)));
            check("ord_ref", 128'(pair_ref[31:0]), 128'(got + 1));
            got++;
         end
         tick();
      end
      check("ord_count", 128'(got), 128'(16));
      extra = 0;
      repeat (30) begin
         if (pair_valid) extra++;
         tick();
      end
      check("ord_extra", 128'(extra), 128'(0));

      // pair_ready toggling: every slot passes, none lost, duplicated or changed while stalled
      for (int k = 0; k < NSIZE; k++) set_slot(k, mkw(k + 1, 0, 0));
      load_snap();
      reference = mkw(0, 0, 0);
      tick();
      reference = NULL_W;
      got = 0;
      for (int cyc = 0; cyc < 200 && got < 14; cyc++) begin
         pair_ready = ((cyc % 2) == 1);
         if (pair_valid) begin
            check("tog_r2",  128'(pair_r2),        128'((got + 1) * (got + 1)));
            check("tog_nbr", 128'(pair_nbr[31:0]), 128'(got + 1));
            if (pair_ready) got++;
         end
         tick();
      end
      pair_ready = 1'b1;
      check("tog_count", 128'(got), 128'(14));
      extra = 0;
      repeat (10) begin
         if (pair_valid) extra++;
         tick();
      end
      check("tog_extra", 128'(extra), 128'(0));

      // batch_done with two queued references; passing neighbour sits in the last slot
      neighbors = {NSIZE{NULL_W}};
      set_slot(NSIZE - 1, mkw(5, 0, 0));
      load_snap();
      check("bd_clear", 128'(batch_done), 128'(0));
      reference = mkw(0, 0, 0);
      done_batch_in = 1'b1;
      tick();
      reference = mkw(1, 0, 0);
      done_batch_in = 1'b0;
      tick();
      reference = NULL_W;
      got = 0;
      for (int cyc = 0; cyc < 100 && got < 2; cyc++) begin
         tick();
         if (pair_valid) begin
            check("bd_r2", 128'(pair_r2), 128'((got == 0) ? 25 : 16));
            got++;
         end
      end
      check("bd_count", 128'(got), 128'(2));
      check("bd_last",  128'(batch_done), 128'(0));
      tick();
      check("bd_accept", 128'(batch_done), 128'(0));
      tick();
      check("bd_rise", 128'(batch_done), 128'(1));
      tick();
      check("bd_hold", 128'(batch_done), 128'(1));

      // Flush mid-sweep; the reference presented with the flush is ignored
      for (int k = 0; k < NSIZE; k++) set_slot(k, mkw(k + 1, 0, 0));
      load_snap();
      reference = mkw(0, 0, 0);
      tick();
      reference = NULL_W;
      repeat (5) tick();
      check("fl_pre", 128'(pair_valid), 128'(1));
      dispatch = 2'b11;
      reference = mkw(0, 0, 0);
      tick();
      dispatch = 2'b00;
      reference = NULL_W;
      check("fl_valid", 128'(pair_valid), 128'(0));
      check("fl_busy",  128'(busy),       128'(0));
      check("fl_bdone", 128'(batch_done), 128'(0));
      check("fl_ovf",   128'(overflow),   128'(1));
      check("fl_drop",  128'(drop_count), 128'(1));
      extra = 0;
      repeat (10) begin
         tick();
         if (pair_valid || busy) extra++;
      end
      check("fl_quiet", 128'(extra), 128'(0));

      // Asynchronous reset mid-sweep
      load_snap();
      reference = mkw(0, 0, 0);
      tick();
      reference = NULL_W;
      repeat (5) tick();
      check("ar_pre", 128'(pair_valid), 128'(1));
      reset = 1'b0;
      #1;
      check("ar_valid", 128'(pair_valid), 128'(0));
      check("ar_ref",   128'(pair_ref),   128'(NULL_W));
      check("ar_nbr",   128'(pair_nbr),   128'(NULL_W));
      check("ar_r2",    128'(pair_r2),    128'(0));
      check("ar_busy",  128'(busy),       128'(0));
      check("ar_ovf",   128'(overflow),   128'(0));
      check("ar_drop",  128'(drop_count), 128'(0));
      tick();
      reset = 1'b1;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pair_filter_queue.md
Name: pair_filter_queue

Overview:
- Sits directly downstream of the position ring node and consumes its `neighbors` bus and its per-cycle `reference` stream.
- Queues valid references and, for each one, sweeps the latched neighbour set one neighbour per cycle.
- Computes the squared distance for each reference/neighbour pair and emits only pairs inside the cutoff, over a valid/ready interface, to the force pipeline.

Parameters:
- NSIZE, 14, neighbour slots per node; must match the ring node.
- RDEPTH, 16, reference FIFO depth (power of two).
- CUTOFF2, 68'h1_0000_0000_0000 (2^48), squared cutoff; a pair passes when r2 < CUTOFF2.

Ports:
- clk, input, 1, sole clock, rising edge.
- reset, input, 1, asynchronous, active-low reset.
- dispatch, input, 2, ring dispatch code (00 idle, 01 new batch, 11 flush).
- neighbors, input, 114*NSIZE, neighbour slots; slot k = bits [k*114 +: 114].
- reference, input, 114, {addr[8:0], cell[7:0], null, z[31:0], y[31:0], x[31:0]}.
- done_batch_in, input, 1, ring node has finished emitting references for this batch.
- pair_ready, input, 1, downstream can accept a pair.
- pair_valid, output, 1, pair_ref/pair_nbr/pair_r2 hold a valid pair.
- pair_ref, output, 114, reference word of the emitted pair.
- pair_nbr, output, 114, neighbour word of the emitted pair.
- pair_r2, output, 68, unsigned squared distance.
- busy, output, 1, FIFO non-empty or pipeline occupied.
- batch_done, output, 1, batch fully filtered.
- overflow, output, 1, sticky error flag.
- drop_count, output, 16, saturating count of dropped references.

Behaviour:
- Word format: bit 96 = null flag; x/y/z are signed 32-bit fixed point.
- Reset (reset low, async) clears all state:
  - pair_valid = 0; pair_ref and pair_nbr = null word (bit 96 = 1, all other bits 0).
  - pair_r2 = 0; busy = 0; batch_done = 0; overflow = 0; drop_count = 0.
  - FIFO empty; snapshot invalid; FSM in IDLE.
- Neighbour snapshot:
  - dispatch is registered internally.
  - On the cycle where dispatch_q == 01, all NSIZE slots are copied into a local snapshot, the snapshot is marked valid, and batch_done clears.
  - If the FIFO is non-empty or the pipeline is occupied when this happens, pending work is discarded and overflow is set.
- Reference intake:
  - Every cycle with reference[96] == 0 and not in flush, the reference is pushed into the FIFO.
  - If the FIFO is full, the reference is dropped: overflow sets and drop_count increments, saturating at 16'hFFFF.
  - A push and a pop in the same cycle are legal when the FIFO is full; the push succeeds.
- FSM:
  - IDLE: go to SWEEP when the FIFO is non-empty and the snapshot is valid; j = 0.
  - SWEEP: each non-stalled cycle, issue (head, slot j) to stage 1 and increment j.
    - A null slot issues a bubble but still consumes the cycle.
    - At j == NSIZE-1, pop the head; go to SWEEP (j = 0) if the FIFO still has data, otherwise DRAIN.
  - DRAIN: wait for the pipeline and output register to empty, then go to IDLE.
- Pipeline:
  - Stage 1: dx, dy, dz as 33-bit signed differences (ref minus nbr).
  - Stage 2: r2 = dx²+dy²+dz², full precision, 68 bits unsigned.
  - Output register: loads when r2 < CUTOFF2 and r2 != 0 (self/duplicate); otherwise the entry becomes a bubble.
  - Latency: with the block idle and the snapshot valid, a reference arriving at cycle t produces pair_valid for slot 0 at t+3.
- Handshake:
  - A transfer occurs when pair_valid && pair_ready.
  - While pair_valid && !pair_ready, the output register, both stages and j all hold; FIFO intake continues.
  - Outputs are stable while stalled.
- batch_done:
  - Set when done_batch_in has been seen (sticky) and the FIFO is empty, the pipeline is empty and pair_valid = 0.
  - Held until the next snapshot or flush.
- Flush: dispatch == 11 (unregistered) takes priority over every other event.
  - FIFO, pipeline, output register, snapshot valid, done latch and batch_done are all cleared; FSM goes to IDLE.
  - overflow and drop_count are retained.
  - References presented in the flush cycle are ignored.
- busy = FIFO non-empty or any stage valid or pair_valid.

Test Plan:
- Snapshot slot0 = (3,4,0), other slots null; reference (0,0,0) -> one pair, pair_r2 = 25, pair_valid at t+3; slots 1..13 emit nothing.
- Slot0 = (2^24,0,0) (r2 = 2^48) and slot1 = (-16777215,0,0) -> only slot1 emitted, with pair_r2 = 0xFFFFFE000001.
- Push 17 references back-to-back with pair_ready = 0 -> 16 stored, overflow = 1, drop_count = 1; after raising pair_ready, all 16 × passing-pair sets drain in order.
- Toggle pair_ready every other cycle during a sweep -> no pair is lost or duplicated, and outputs are stable while stalled.
- Assert done_batch_in with 2 references queued -> batch_done rises exactly one cycle after the last pair is accepted.
- dispatch = 11 mid-sweep -> next cycle pair_valid = 0, busy = 0, batch_done = 0, overflow unchanged; assert reset low mid-sweep -> all outputs return to reset values immediately.
